// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam int unsigned BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Nibbles 10..15 are not reachable from a 13-bit value; they decode to blank.
  function automatic logic [6:0] seg(input logic [3:0] digit);
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one shift per clock.
// start is sampled in IDLE; done is high for the single DONE cycle.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int unsigned VAL_W = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VAL_W-1:0]        value,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic [VAL_W-1:0]        value_cap,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CntW = $clog2(VAL_W + 1);
  localparam logic [CntW-1:0] LastShift = CntW'(VAL_W - 1);

  state_e                  state_q, state_d;
  logic [VAL_W-1:0]        bin_q, bin_d;
  logic [VAL_W-1:0]        cap_q, cap_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CntW-1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    cap_d   = cap_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = value;
          cap_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[4*BCD_DIGITS-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LastShift) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bcd       = bcd_q;
  assign value_cap = cap_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: rtl/ssd_display_driver.sv
// 4-digit multiplexed seven-segment driver fed by a 13-bit binary value.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above the ones digit.
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned VAL_W       = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value,
  output logic [3:0]       anode,
  output logic [6:0]       cathode,
  output logic             busy
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [4*BCD_DIGITS-1:0] digits_q, conv_bcd;
  logic [VAL_W-1:0]        last_q, conv_cap;
  logic                    conv_busy, conv_done, start;
  logic [CntW-1:0]         refresh_q;
  logic [1:0]              idx_q;
  logic [3:0]              anode_q, anode_d, digit;
  logic [6:0]              cathode_q, cathode_d;
  logic                    blank;

  // Only a value differing from what is already shown starts a conversion.
  assign start = !conv_busy && (value != last_q);

  bin2bcd_seq #(
    .VAL_W(VAL_W)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .bcd      (conv_bcd),
    .value_cap(conv_cap),
    .busy     (conv_busy),
    .done     (conv_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q <= '0;
      last_q   <= '0;
    end else if (conv_done) begin
      digits_q <= conv_bcd;
      last_q   <= conv_cap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CntMax) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;
  assign lead_zero[3] = (digits_q[15:12] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (digits_q[11:8] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (digits_q[7:4] == 4'd0);
  assign lead_zero[0] = 1'b0;
  assign blank        = lead_zero[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    digit     = digits_q[4*idx_q +: 4];
    anode_d   = ~(4'b0001 << idx_q);
    cathode_d = blank ? SEG_OFF : seg(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_q   <= 4'b1111;
      cathode_q <= SEG_OFF;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign busy    = conv_busy;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Self-checking bench for ssd_display_driver with REFRESH_DIV=4.
module tb_ssd_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ssd_display_driver #(
    .REFRESH_DIV(4),
    .VAL_W      (13)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .value  (value),
    .anode  (anode),
    .cathode(cathode),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Expected cathode pattern for digit position idx of displayed decimal value v.
  function automatic logic [6:0] exp_cathode(input int v, input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return 7'b1111111;
`endif
    return seg_of((v / p) % 10);
  endfunction

  function automatic int anode_idx(input logic [3:0] a);
    logic [3:0] pat;
    anode_idx = -1;
    for (int j = 0; j < 4; j++) begin
      pat = ~(4'b0001 << j);
      if (a === pat) anode_idx = j;
    end
  endfunction

  task automatic test_reset();
    logic [3:0] ea;
    rst   = 1'b0;
    value = '0;
    repeat (2) @(negedge clk);
    total++;
    if (anode !== 4'b1111 || cathode !== 7'b1111111 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: anode=%b cathode=%b busy=%b, want 1111 1111111 0",
               anode, cathode, busy);
    end
    total++;
    if (dut.digits_q !== 16'h0000) begin
      bad++;
      $display("FAIL reset_digits: got %h want 0000", dut.digits_q);
    end
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      ea = ~(4'b0001 << (((n - 1) / 4) % 4));
      total++;
      if (anode !== ea || cathode !== exp_cathode(0, ((n - 1) / 4) % 4) || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_scan cyc %0d: anode=%b cathode=%b busy=%b, want %b %b 0",
                 n, anode, cathode, busy, ea, exp_cathode(0, ((n - 1) / 4) % 4));
      end
    end
  endtask

  task automatic test_max();
    int idx;
    value = 13'd8191;
    for (int e = 0; e <= 13; e++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || dut.digits_q !== 16'h0000) begin
        bad++;
        $display("FAIL max_busy E%0d: busy=%b digits=%h, want 1 0000", e, busy, dut.digits_q);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.digits_q !== to_bcd(8191)) begin
      bad++;
      $display("FAIL max_done E14: busy=%b digits=%h, want 0 %h", busy, dut.digits_q,
               to_bcd(8191));
    end
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      idx = anode_idx(anode);
      total++;
      if (idx < 0 || cathode !== exp_cathode(8191, idx)) begin
        bad++;
        $display("FAIL max_scan: anode=%b cathode=%b idx=%0d", anode, cathode, idx);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    value = 13'd42;
    for (int e = 0; e <= 29; e++) begin
      @(negedge clk);
      exp = (e < 14) ? to_bcd(8191) : (e < 29) ? to_bcd(42) : to_bcd(1234);
      total++;
      if (dut.digits_q !== exp) begin
        bad++;
        $display("FAIL b2b_digits E%0d: got %h want %h", e, dut.digits_q, exp);
      end
      if (e == 14 || e == 15 || e == 29) begin
        total++;
        if (busy !== (e == 15)) begin
          bad++;
          $display("FAIL b2b_busy E%0d: got %b want %b", e, busy, (e == 15));
        end
      end
      if (e == 4) value = 13'd1234;
    end
  endtask

  task automatic test_reset_abort();
    int idx;
    value = 13'd500;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (anode !== 4'b1111 || cathode !== 7'b1111111 || busy !== 1'b0 ||
        dut.digits_q !== 16'h0000) begin
      bad++;
      $display("FAIL abort_async: anode=%b cathode=%b busy=%b digits=%h", anode, cathode,
               busy, dut.digits_q);
    end
    value = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      idx = anode_idx(anode);
      total++;
      if (busy !== 1'b0 || dut.digits_q !== 16'h0000 || idx < 0 ||
          cathode !== exp_cathode(0, idx)) begin
        bad++;
        $display("FAIL abort_after: busy=%b digits=%h anode=%b cathode=%b", busy,
                 dut.digits_q, anode, cathode);
      end
    end
  endtask

  task automatic test_blank();
    int idx;
    int k;
    value = 13'd7;
    k = 0;
    while (busy !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    while (busy !== 1'b0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 80) begin
      bad++;
      $display("FAIL blank_timeout: busy=%b after %0d cycles, want 0", busy, k);
    end
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      idx = anode_idx(anode);
      total++;
      if (idx < 0 || cathode !== exp_cathode(7, idx)) begin
        bad++;
        $display("FAIL blank_scan: anode=%b cathode=%b want %b", anode, cathode,
                 (idx < 0) ? 7'b0 : exp_cathode(7, idx));
      end
    end
  endtask

  task automatic test_sweep();
    int vals[$];
    int last = 7;
    int v;
    vals = '{1, 0, 9, 10, 99, 100, 999, 1000, 4095, 8190, 8191};
    for (int i = 0; i < 1000; i++) vals.push_back(int'($urandom_range(0, 8191)));
    foreach (vals[i]) begin
      v = vals[i];
      if (v == last) v = (v + 1) % 8192;
      value = 13'(v);
      repeat (15) @(negedge clk);
      total++;
      if (dut.digits_q !== to_bcd(v) || busy !== 1'b0) begin
        bad++;
        $display("FAIL sweep_%0d: digits=%h busy=%b, want %h 0", v, dut.digits_q, busy,
                 to_bcd(v));
      end
      last = v;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_reset_abort();
    test_blank();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
